mem_port_arbiter: RTL and testbench

- Sequences a single-ported unified RAM between the instruction-fetch port and the data-memory port of the pipelined MIPS core.
- Latches one request at a time, drives the RAM until it signals ready, then returns a one-cycle ihit/dhit pulse with registered load data.
- The hazard unit consumes these pulses to enable or stall the pipeline registers.
- Data has priority; a streak limit bounds instruction-fetch starvation.

---
 rtl/mem_port_arbiter_if.sv | 46 ++++
 rtl/mem_port_arbiter.sv | 121 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if
// Bundles every signal the arbiter exchanges with the core (instruction and
// data ports) and with the single-ported RAM.
//   slave  : arbiter view. It receives requests and RAM responses, and drives
//            hits, load data, RAM strobes and busy.
//   master : environment view (core + RAM). It is the mirror image of slave.
// Port summary:
//   iREN/iaddr             instruction fetch request (level) and address
//   ihit/iload             fetch completion pulse and registered word
//   dREN/dWEN/daddr/dstore data request (level), address and write data
//   dhit/dload             data completion pulse and registered read data
//   ramREN/ramWEN/ramaddr/ramstore  RAM command side
//   ramload/ram_ready      RAM response side
//   busy                   arbiter is not idle
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              iREN;
  logic [ADDR_W-1:0] iaddr;
  logic              ihit;
  logic [DATA_W-1:0] iload;
  logic              dREN;
  logic              dWEN;
  logic [ADDR_W-1:0] daddr;
  logic [DATA_W-1:0] dstore;
  logic              dhit;
  logic [DATA_W-1:0] dload;
  logic              ramREN;
  logic              ramWEN;
  logic [ADDR_W-1:0] ramaddr;
  logic [DATA_W-1:0] ramstore;
  logic [DATA_W-1:0] ramload;
  logic              ram_ready;
  logic              busy;

  modport slave (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ram_ready,
    output ihit, iload, dhit, dload, ramREN, ramWEN, ramaddr, ramstore, busy
  );

  modport master (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ram_ready,
    input  ihit, iload, dhit, dload, ramREN, ramWEN, ramaddr, ramstore, busy
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one single-ported RAM between the instruction-fetch port and the
// data port of a pipelined core. One request is latched at a time, the RAM is
// driven from the latched copy until ram_ready, and a one-cycle ihit/dhit is
// returned with registered load data. Data requests win, but after
// MAX_DSTREAK consecutive data grants made while a fetch waits, the fetch is
// forced through.
// Ports:
//   CLK   rising-edge clock
//   nRST  asynchronous active-low reset
//   bus   mem_port_arbiter_if.slave (core request/response and RAM signals)
module mem_port_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MAX_DSTREAK = 4
) (
  input  logic                 CLK,
  input  logic                 nRST,
  mem_port_arbiter_if.slave    bus
);

  localparam int SW = (MAX_DSTREAK < 1) ? 1 : $clog2(MAX_DSTREAK + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DSTREAK);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    IACC  = 3'd1,
    DACC  = 3'd2,
    IRESP = 3'd3,
    DRESP = 3'd4
  } state_t;

  state_t            state_q,  state_d;
  logic [ADDR_W-1:0] addr_q,   addr_d;
  logic [DATA_W-1:0] store_q,  store_d;
  logic              wr_q,     wr_d;
  logic [SW-1:0]     streak_q, streak_d;
  logic [DATA_W-1:0] iload_q,  iload_d;
  logic [DATA_W-1:0] dload_q,  dload_d;
  logic              dreq;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      store_q  <= '0;
      wr_q     <= 1'b0;
      streak_q <= '0;
      iload_q  <= '0;
      dload_q  <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      store_q  <= store_d;
      wr_q     <= wr_d;
      streak_q <= streak_d;
      iload_q  <= iload_d;
      dload_q  <= dload_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    store_d  = store_q;
    wr_d     = wr_q;
    streak_d = streak_q;
    iload_d  = iload_q;
    dload_d  = dload_q;
    dreq     = bus.dREN | bus.dWEN;

    case (state_q)
      IDLE: begin
        // The streak only measures starvation of a fetch that is actually waiting.
        if (!bus.iREN) streak_d = '0;
        if (dreq && !(bus.iREN && streak_q == STREAK_MAX)) begin
          state_d = DACC;
          addr_d  = bus.daddr;
          store_d = bus.dstore;
          wr_d    = bus.dWEN;
          if (bus.iREN && streak_q != STREAK_MAX) streak_d = streak_q + 1'b1;
        end else if (bus.iREN) begin
          state_d  = IACC;
          addr_d   = bus.iaddr;
          wr_d     = 1'b0;
          streak_d = '0;
        end
      end
      IACC: begin
        if (bus.ram_ready) begin
          iload_d = bus.ramload;
          state_d = IRESP;
        end
      end
      DACC: begin
        if (bus.ram_ready) begin
          if (!wr_q) dload_d = bus.ramload;
          state_d = DRESP;
        end
      end
      IRESP, DRESP: begin
        // Requests are not looked at here, so a requester still holding its
        // request while it sees the hit is not granted a second time.
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // RAM command outputs are driven only during an access, from the latched request.
  assign bus.ramREN   = (state_q == IACC) || (state_q == DACC && !wr_q);
  assign bus.ramWEN   = (state_q == DACC) && wr_q;
  assign bus.ramaddr  = (state_q == IACC || state_q == DACC) ? addr_q : '0;
  assign bus.ramstore = (state_q == DACC && wr_q) ? store_q : '0;
  assign bus.ihit     = (state_q == IRESP);
  assign bus.dhit     = (state_q == DRESP);
  assign bus.iload    = iload_q;
  assign bus.dload    = dload_q;
  assign bus.busy     = (state_q != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
// Drives the arbiter as both the core and the RAM. A transaction-level model
// tracks which request owns the RAM, the pending hit, the data streak and the
// captured load words, and is compared with the DUT on every negative edge.
// Directed sequences pin the model with hand-computed literal values.
module tb_mem_port_arbiter;

  localparam int ADDR_W      = 32;
  localparam int DATA_W      = 32;
  localparam int MAX_DSTREAK = 4;

  logic CLK;
  logic nRST;
  logic check_en;
  int   checks;
  int   failures;

  mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  mem_port_arbiter #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W),
    .MAX_DSTREAK(MAX_DSTREAK)
  ) dut (
    .CLK(CLK),
    .nRST(nRST),
    .bus(bus.slave)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Model state: who owns the RAM, which hit is due, and the visible load words.
  logic        m_access = 1'b0;
  logic        m_instr  = 1'b0;
  logic        m_write  = 1'b0;
  logic [31:0] m_addr   = '0;
  logic [31:0] m_store  = '0;
  int          m_hit    = 0;
  int          m_streak = 0;
  logic [31:0] m_iload  = '0;
  logic [31:0] m_dload  = '0;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // One cycle of stimulus: inputs change just after the rising edge, and the
  // task returns after the falling edge so outputs of that cycle can be checked.
  task automatic apply_stimulus(input logic i_ren, input logic [31:0] i_addr,
                                input logic d_ren, input logic d_wen,
                                input logic [31:0] d_addr, input logic [31:0] d_store,
                                input logic rdy, input logic [31:0] r_load);
    @(posedge CLK);
    #2;
    bus.iREN      = i_ren;
    bus.iaddr     = i_addr;
    bus.dREN      = d_ren;
    bus.dWEN      = d_wen;
    bus.daddr     = d_addr;
    bus.dstore    = d_store;
    bus.ram_ready = rdy;
    bus.ramload   = r_load;
    @(negedge CLK);
    #1;
  endtask

  task automatic idle_cycle();
    apply_stimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
  endtask

  // Compare process: check DUT against the model, then advance the model with
  // the inputs that the next rising edge will sample.
  always @(negedge CLK) begin
    if (check_en) begin
      if (!nRST) begin
        m_access = 1'b0;
        m_hit    = 0;
        m_streak = 0;
        m_addr   = '0;
        m_store  = '0;
        m_write  = 1'b0;
        m_iload  = '0;
        m_dload  = '0;
      end
      check_output("model_busy",    {31'b0, bus.busy},   {31'b0, (m_access || m_hit != 0)});
      check_output("model_ihit",    {31'b0, bus.ihit},   {31'b0, (m_hit == 1)});
      check_output("model_dhit",    {31'b0, bus.dhit},   {31'b0, (m_hit == 2)});
      check_output("model_ramREN",  {31'b0, bus.ramREN}, {31'b0, (m_access && (m_instr || !m_write))});
      check_output("model_ramWEN",  {31'b0, bus.ramWEN}, {31'b0, (m_access && !m_instr && m_write)});
      check_output("model_ramaddr", bus.ramaddr,  m_access ? m_addr : 32'h0);
      check_output("model_ramstore", bus.ramstore, (m_access && !m_instr && m_write) ? m_store : 32'h0);
      check_output("model_iload",   bus.iload, m_iload);
      check_output("model_dload",   bus.dload, m_dload);

      if (nRST) begin
        if (m_hit != 0) begin
          m_hit = 0;
        end else if (m_access) begin
          if (bus.ram_ready) begin
            if (m_instr) begin
              m_iload = bus.ramload;
              m_hit   = 1;
            end else begin
              if (!m_write) m_dload = bus.ramload;
              m_hit = 2;
            end
            m_access = 1'b0;
          end
        end else begin
          if (!bus.iREN) m_streak = 0;
          if ((bus.dREN || bus.dWEN) && !(bus.iREN && m_streak >= MAX_DSTREAK)) begin
            m_access = 1'b1;
            m_instr  = 1'b0;
            m_write  = bus.dWEN;
            m_addr   = bus.daddr;
            m_store  = bus.dstore;
            if (bus.iREN) m_streak = (m_streak + 1 > MAX_DSTREAK) ? MAX_DSTREAK : m_streak + 1;
          end else if (bus.iREN) begin
            m_access = 1'b1;
            m_instr  = 1'b1;
            m_write  = 1'b0;
            m_addr   = bus.iaddr;
            m_store  = '0;
            m_streak = 0;
          end
        end
      end
    end
  end

  // Guard against any sequence that fails to terminate.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [9:0] exp_w;
    checks   = 0;
    failures = 0;
    check_en = 1'b0;
    nRST     = 1'b0;
    bus.iREN = 1'b0; bus.iaddr = '0; bus.dREN = 1'b0; bus.dWEN = 1'b0;
    bus.daddr = '0; bus.dstore = '0; bus.ram_ready = 1'b0; bus.ramload = '0;

    // Reset state.
    #3;
    check_output("rst_busy",     {31'b0, bus.busy},   32'h0);
    check_output("rst_ihit",     {31'b0, bus.ihit},   32'h0);
    check_output("rst_dhit",     {31'b0, bus.dhit},   32'h0);
    check_output("rst_ramREN",   {31'b0, bus.ramREN}, 32'h0);
    check_output("rst_ramWEN",   {31'b0, bus.ramWEN}, 32'h0);
    check_output("rst_ramaddr",  bus.ramaddr,  32'h0);
    check_output("rst_ramstore", bus.ramstore, 32'h0);
    check_output("rst_iload",    bus.iload,    32'h0);
    check_output("rst_dload",    bus.dload,    32'h0);
    #4;
    nRST     = 1'b1;
    check_en = 1'b1;

    // Single fetch, held through its ihit and then dropped.
    apply_stimulus(1'b1, 32'h40, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    check_output("fetch_c0_busy", {31'b0, bus.busy}, 32'h0);
    apply_stimulus(1'b1, 32'h40, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h8C220004);
    check_output("fetch_c1_ramREN", {31'b0, bus.ramREN}, 32'h1);
    check_output("fetch_c1_ramWEN", {31'b0, bus.ramWEN}, 32'h0);
    check_output("fetch_c1_ramaddr", bus.ramaddr, 32'h40);
    apply_stimulus(1'b1, 32'h40, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h0);
    check_output("fetch_c2_ihit", {31'b0, bus.ihit}, 32'h1);
    check_output("fetch_c2_iload", bus.iload, 32'h8C220004);
    check_output("fetch_c2_ramREN", {31'b0, bus.ramREN}, 32'h0);
    idle_cycle();
    check_output("hold_c3_busy", {31'b0, bus.busy}, 32'h0);
    idle_cycle();
    check_output("hold_c4_busy", {31'b0, bus.busy}, 32'h0);
    check_output("hold_c4_ramREN", {31'b0, bus.ramREN}, 32'h0);

    // Simultaneous requests: data first, then the fetch.
    apply_stimulus(1'b1, 32'h40, 1'b1, 1'b0, 32'h100, 32'h0, 1'b1, 32'h12345678);
    check_output("simul_c0_busy", {31'b0, bus.busy}, 32'h0);
    apply_stimulus(1'b1, 32'h40, 1'b1, 1'b0, 32'h100, 32'h0, 1'b1, 32'h12345678);
    check_output("simul_c1_ramaddr", bus.ramaddr, 32'h100);
    check_output("simul_c1_ramREN", {31'b0, bus.ramREN}, 32'h1);
    apply_stimulus(1'b1, 32'h40, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h0);
    check_output("simul_c2_dhit", {31'b0, bus.dhit}, 32'h1);
    check_output("simul_c2_ihit", {31'b0, bus.ihit}, 32'h0);
    check_output("simul_c2_dload", bus.dload, 32'h12345678);
    apply_stimulus(1'b1, 32'h40, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h0);
    check_output("simul_c3_busy", {31'b0, bus.busy}, 32'h0);
    apply_stimulus(1'b1, 32'h40, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h0BADF00D);
    check_output("simul_c4_ramaddr", bus.ramaddr, 32'h40);
    check_output("simul_c4_ramREN", {31'b0, bus.ramREN}, 32'h1);
    idle_cycle();
    check_output("simul_c5_ihit", {31'b0, bus.ihit}, 32'h1);
    check_output("simul_c5_iload", bus.iload, 32'h0BADF00D);
    idle_cycle();

    // Write stalled by the RAM for three cycles; daddr moves mid-access.
    apply_stimulus(1'b0, 32'h0, 1'b0, 1'b1, 32'h200, 32'hDEADBEEF, 1'b0, 32'hFFFFFFFF);
    check_output("wr_c0_busy", {31'b0, bus.busy}, 32'h0);
    for (int c = 1; c <= 4; c++) begin
      apply_stimulus(1'b0, 32'h0, 1'b0, 1'b1, 32'h300, 32'h0, (c == 4), 32'hFFFFFFFF);
      check_output("wr_stall_ramWEN", {31'b0, bus.ramWEN}, 32'h1);
      check_output("wr_stall_ramREN", {31'b0, bus.ramREN}, 32'h0);
      check_output("wr_stall_ramaddr", bus.ramaddr, 32'h200);
      check_output("wr_stall_ramstore", bus.ramstore, 32'hDEADBEEF);
    end
    idle_cycle();
    check_output("wr_c5_dhit", {31'b0, bus.dhit}, 32'h1);
    check_output("wr_c5_dload", bus.dload, 32'h12345678);
    idle_cycle();

    // Asynchronous reset in the middle of a data read.
    apply_stimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h80, 32'h0, 1'b0, 32'h0);
    apply_stimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h80, 32'h0, 1'b0, 32'h0);
    check_output("arst_pre_ramREN", {31'b0, bus.ramREN}, 32'h1);
    check_output("arst_pre_ramaddr", bus.ramaddr, 32'h80);
    #2;
    nRST = 1'b0;
    #1;
    check_output("arst_busy",    {31'b0, bus.busy},   32'h0);
    check_output("arst_ramREN",  {31'b0, bus.ramREN}, 32'h0);
    check_output("arst_ramaddr", bus.ramaddr, 32'h0);
    check_output("arst_dload",   bus.dload,   32'h0);
    check_output("arst_iload",   bus.iload,   32'h0);
    idle_cycle();
    #1;
    nRST = 1'b1;
    for (int c = 0; c < 3; c++) begin
      idle_cycle();
      check_output("arst_after_dhit", {31'b0, bus.dhit}, 32'h0);
      check_output("arst_after_busy", {31'b0, bus.busy}, 32'h0);
    end

    // Starvation bound: four data writes, then one forced fetch, repeating.
    exp_w = 10'b0111101111;
    for (int k = 0; k < 30; k++) begin
      apply_stimulus(1'b1, 32'h40, 1'b0, 1'b1, 32'h500, 32'hA5A5A5A5, 1'b1, 32'h77);
      if (k % 3 == 1) begin
        check_output("starve_ramWEN", {31'b0, bus.ramWEN}, {31'b0, exp_w[(k - 1) / 3]});
        check_output("starve_ramREN", {31'b0, bus.ramREN}, {31'b0, ~exp_w[(k - 1) / 3]});
      end
    end
    idle_cycle();
    idle_cycle();
    idle_cycle();

    // Randomized traffic against the model.
    for (int n = 0; n < 2000; n++) begin
      apply_stimulus(($urandom_range(0, 3) != 0), {$urandom_range(0, 255), 2'b00} ,
                     ($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0),
                     {$urandom_range(0, 255), 2'b00}, $urandom(),
                     ($urandom_range(0, 2) != 0), $urandom());
    end
    idle_cycle();
    idle_cycle();
    idle_cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
